// File: rtl/seq_detect_fsm.sv
// Serial pattern detector: one-cycle match pulse when the last PAT_W accepted bits equal PATTERN.
// Optional sticky 'seen' output enabled by defining SEQ_DET_STICKY_EN.
module seq_detect_fsm #(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             x,
  input  logic             overlap,
  input  logic             clr,
  output logic             y,
  output logic [CNT_W-1:0] match_count,
  output logic [1:0]       state
`ifdef SEQ_DET_STICKY_EN
  ,
  output logic             seen
`endif
);

  localparam int unsigned      FillW    = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFill  = 2'd1,
    StFull  = 2'd2
  } state_e;

  logic [PAT_W-1:0] r_hist, w_hist_nxt;
  logic [FillW-1:0] r_fill, w_fill_nxt;
  state_e           r_state, w_state_nxt;
  logic             r_y, w_y_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;

  logic [PAT_W-1:0] w_hist_shift;
  logic [FillW-1:0] w_fill_inc;
  logic             w_match;

  // Match is judged on the post-shift history so latency is exactly one edge.
  assign w_hist_shift = {r_hist[PAT_W-2:0], x};
  assign w_fill_inc   = (r_fill == FillFull) ? FillFull : r_fill + FillW'(1);
  assign w_match      = in_valid && (w_fill_inc == FillFull) && (w_hist_shift == PATTERN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_state <= StEmpty;
      r_y     <= 1'b0;
      r_count <= '0;
    end else begin
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_state <= w_state_nxt;
      r_y     <= w_y_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_state_nxt = r_state;
    w_y_nxt     = 1'b0;
    w_count_nxt = r_count;
    if (clr) begin
      w_hist_nxt  = '0;
      w_fill_nxt  = '0;
      w_state_nxt = StEmpty;
      w_count_nxt = '0;
    end else if (in_valid) begin
      w_hist_nxt  = w_hist_shift;
      w_fill_nxt  = w_fill_inc;
      w_state_nxt = (w_fill_inc == FillFull) ? StFull : StFill;
      if (w_match) begin
        w_y_nxt = 1'b1;
        if (!(&r_count)) begin
          w_count_nxt = r_count + CNT_W'(1);
        end
        if (!overlap) begin
          w_hist_nxt  = '0;
          w_fill_nxt  = '0;
          w_state_nxt = StEmpty;
        end
      end
    end
  end

  assign y           = r_y;
  assign match_count = r_count;
  assign state       = r_state;

`ifdef SEQ_DET_STICKY_EN
  logic r_seen, w_seen_nxt;

  always_comb begin
    w_seen_nxt = r_seen;
    if (clr) begin
      w_seen_nxt = 1'b0;
    end else if (w_match) begin
      w_seen_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seen <= 1'b0;
    end else begin
      r_seen <= w_seen_nxt;
    end
  end

  assign seen = r_seen;
`endif

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: two instances (CNT_W=8 and CNT_W=2) driven in lockstep against a
// queue-based model of the last accepted bits.
module tb_seq_detect_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, x, overlap, clr;
  logic       y8, y2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  logic [1:0] st8, st2;
`ifdef SEQ_DET_STICKY_EN
  logic       seen8, seen2;
`endif

  always #5 clk = ~clk;

  seq_detect_fsm #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) u_dut8 (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .x           (x),
    .overlap     (overlap),
    .clr         (clr),
    .y           (y8),
    .match_count (cnt8),
    .state       (st8)
`ifdef SEQ_DET_STICKY_EN
    ,
    .seen        (seen8)
`endif
  );

  seq_detect_fsm #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) u_dut2 (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .x           (x),
    .overlap     (overlap),
    .clr         (clr),
    .y           (y2),
    .match_count (cnt2),
    .state       (st2)
`ifdef SEQ_DET_STICKY_EN
    ,
    .seen        (seen2)
`endif
  );

  int          n_checks = 0;
  int          n_err    = 0;
  int          n_pulse  = 0;
  bit [3:0]    pat_v;
  bit          mq[$];
  int unsigned m_cnt;
  bit          m_y, m_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_cnt  = 0;
    m_y    = 1'b0;
    m_seen = 1'b0;
  endtask

  function automatic bit model_hit();
    bit ok = 1'b1;
    if (mq.size() != 4) return 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mq[i] != pat_v[3-i]) ok = 1'b0;
    end
    return ok;
  endfunction

  // Applied once per rising edge with the inputs that edge samples.
  task automatic model_edge();
    if (clr) begin
      model_clear();
    end else begin
      m_y = 1'b0;
      if (in_valid) begin
        mq.push_back(x);
        if (mq.size() > 4) void'(mq.pop_front());
        if (model_hit()) begin
          m_y    = 1'b1;
          m_cnt  = m_cnt + 1;
          m_seen = 1'b1;
          if (!overlap) mq.delete();
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_state();
    if (mq.size() == 0) return 0;
    if (mq.size() < 4) return 1;
    return 2;
  endfunction

  task automatic compare_all();
    check("y8", 32'(y8), 32'(m_y));
    check("y2", 32'(y2), 32'(m_y));
    check("count8", 32'(cnt8), (m_cnt > 255) ? 32'd255 : m_cnt);
    check("count2", 32'(cnt2), (m_cnt > 3) ? 32'd3 : m_cnt);
    check("state8", 32'(st8), exp_state());
    check("state2", 32'(st2), exp_state());
`ifdef SEQ_DET_STICKY_EN
    check("seen8", 32'(seen8), 32'(m_seen));
    check("seen2", 32'(seen2), 32'(m_seen));
`endif
    if (y8) n_pulse++;
  endtask

  task automatic step(input logic v, input logic b, input logic c);
    in_valid = v;
    x        = b;
    clr      = c;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic feed(input bit [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0);
  endtask

  initial begin
    pat_v    = 4'b1011;
    reset    = 1'b1;
    in_valid = 1'b0;
    x        = 1'b0;
    overlap  = 1'b1;
    clr      = 1'b0;
    model_clear();
    #1 reset = 1'b0;
    #9;
    compare_all();
    check("rst_state", 32'(st8), 32'd0);
    check("rst_count", 32'(cnt8), 32'd0);
    #2 reset = 1'b1;

    // Zeros fill the history without matching.
    step(1'b1, 1'b0, 1'b0);
    check("t1_state_fill", 32'(st8), 32'd1);
    feed(16'b000, 3);
    check("t1_state_full", 32'(st8), 32'd2);
    check("t1_count", 32'(cnt8), 32'd0);
    step(1'b0, 1'b0, 1'b1);

    // Single match, pulse one cycle after the 4th bit.
    feed(16'b101, 3);
    check("t2_y_early", 32'(y8), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    check("t2_y", 32'(y8), 32'd1);
    check("t2_count", 32'(cnt8), 32'd1);
    check("t2_state", 32'(st8), 32'd2);
    step(1'b0, 1'b0, 1'b0);
    check("t2_y_drop", 32'(y8), 32'd0);
    step(1'b0, 1'b0, 1'b1);

    // Overlapping versus non-overlapping.
    n_pulse = 0;
    feed(16'b1011011, 7);
    check("t3_ov_pulses", 32'(n_pulse), 32'd2);
    check("t3_ov_count", 32'(cnt8), 32'd2);
    step(1'b0, 1'b0, 1'b1);
    overlap = 1'b0;
    n_pulse = 0;
    feed(16'b1011, 4);
    check("t3_nov_state_mid", 32'(st8), 32'd0);
    feed(16'b011, 3);
    check("t3_nov_pulses", 32'(n_pulse), 32'd1);
    check("t3_nov_count", 32'(cnt8), 32'd1);
    check("t3_nov_state", 32'(st8), 32'd1);
    overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1);

    // Qualifier gaps, with unknown data while not valid.
    n_pulse = 0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'bx, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'bx, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("t4_y", 32'(y8), 32'd1);
    check("t4_pulses", 32'(n_pulse), 32'd1);

    // Asynchronous reset mid-stream.
    feed(16'b101, 3);
    #1 reset = 1'b0;
    model_clear();
    #1;
    compare_all();
    check("t4_rst_state", 32'(st8), 32'd0);
    check("t4_rst_count", 32'(cnt8), 32'd0);
    #1 reset = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    check("t4_after_y", 32'(y8), 32'd0);
    check("t4_after_state", 32'(st8), 32'd1);

    // Clear wins over a simultaneous completing bit.
    step(1'b0, 1'b0, 1'b1);
    feed(16'b101, 3);
    step(1'b1, 1'b1, 1'b1);
    check("t5_clr_y", 32'(y8), 32'd0);
    check("t5_clr_state", 32'(st8), 32'd0);
    check("t5_clr_count", 32'(cnt8), 32'd0);
    feed(16'b1011, 4);
    check("t5_count", 32'(cnt8), 32'd1);
    step(1'b0, 1'b0, 1'b1);

    // Saturation of the narrow counter; sticky flag if built in.
    n_pulse = 0;
    feed(16'b1011011011011, 13);
    check("t6_pulses", 32'(n_pulse), 32'd4);
    check("t6_count2", 32'(cnt2), 32'd3);
    check("t6_count8", 32'(cnt8), 32'd4);
`ifdef SEQ_DET_STICKY_EN
    check("t6_seen", 32'(seen2), 32'd1);
`endif
    step(1'b0, 1'b0, 1'b1);
    check("t6_clr_count2", 32'(cnt2), 32'd0);
`ifdef SEQ_DET_STICKY_EN
    check("t6_clr_seen", 32'(seen2), 32'd0);
`endif
    step(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
